// File: rtl/hs_mem_fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO on top of an async-read dual-port RAM.
// The RAM primitive is kept in this file so the FIFO is self-contained.

module hs_mem_dpram_asyncrd #(
  parameter type DATA_TYPE  = logic [7:0],
  parameter int  DATA_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] wr0addr,
  input  DATA_TYPE              wdata,
  output DATA_TYPE              r0data,
  input  logic [ADDR_WIDTH-1:0] r1addr,
  output DATA_TYPE              r1data
);

  // Storage is deliberately never reset; only FIFO bookkeeping is.
  DATA_TYPE mem_q [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[wr0addr] <= wdata;
    end
  end

  assign r0data = mem_q[wr0addr];
  assign r1data = mem_q[r1addr];

endmodule

module hs_mem_fifo_sync_fwft #(
  parameter type DATA_TYPE   = logic [7:0],
  parameter int  DATA_DEPTH  = 16,
  parameter int  AFULL_LEVEL = DATA_DEPTH - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  DATA_TYPE                         wdata,
  input  logic                             wvalid,
  output logic                             wready,
  output DATA_TYPE                         rdata,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [$clog2(DATA_DEPTH+1)-1:0]  count,
  output logic                             afull
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  push;
  logic                  pop;

  // Pointers wrap at DATA_DEPTH-1 so non-power-of-2 depths use exactly DATA_DEPTH slots.
  function automatic logic [ADDR_WIDTH-1:0] nextPtr(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
  endfunction

  assign wready = (count_q != CNT_WIDTH'(DATA_DEPTH));
  assign rvalid = (count_q != '0);
  assign afull  = (count_q >= CNT_WIDTH'(AFULL_LEVEL));
  assign count  = count_q;

  assign push = wvalid && wready && !rst;
  assign pop  = rready && rvalid;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end
    if (pop) begin
      rdPtr_d = nextPtr(rdPtr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  hs_mem_dpram_asyncrd #(
    .DATA_TYPE  (DATA_TYPE),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wen     (push),
    .wr0addr (wrPtr_q),
    .wdata   (wdata),
    .r0data  (),
    .r1addr  (rdPtr_q),
    .r1data  (rdata)
  );

endmodule
